// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN core scheduler slice.
// Holds the scheduler FSM encoding and core sizing constants.
package snn_pkg;

  localparam int EVT_ADDR_W  = 4;
  localparam int NUM_NEURONS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_EV = 2'd2,
    LEAK    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
// Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         i_req,
  input  logic [$clog2(NUM_SRC)-1:0] i_ptr,
  output logic [NUM_SRC-1:0]         o_grant,
  output logic [$clog2(NUM_SRC)-1:0] o_idx
);

  localparam int IW = $clog2(NUM_SRC);

  logic w_found;

  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = int'(i_ptr) + i;
      if (k >= NUM_SRC) k = k - NUM_SRC;
      if (!w_found && i_req[k]) begin
        w_found    = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/snn_event_sched.sv
// Event/leak scheduler: owns membrane memory for one pass at a time.
// Optional watchdog enabled by defining SNN_SCHED_WATCHDOG_EN.
module snn_event_sched
  import snn_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int ADDR_W    = EVT_ADDR_W,
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  output logic [NUM_SRC-1:0]         src_pop,
  output logic                       event_received,
  output logic [ADDR_W-1:0]          event_addr,
  output logic [$clog2(NUM_SRC)-1:0] event_src,
  input  logic                       event_done,
  input  logic                       timestep_tick,
  output logic                       leak_req,
  input  logic                       leak_ack,
  output logic                       busy,
  output logic                       leak_overrun,
  output logic                       sched_err
);

  localparam int IW = $clog2(NUM_SRC);

  sched_state_t r_state, w_state_nxt;

  logic [IW-1:0]      r_rr_ptr;
  logic               r_leak_pending;
  logic               r_leak_overrun;
  logic [ADDR_W-1:0]  r_event_addr;
  logic [IW-1:0]      r_event_src;
  logic [NUM_SRC-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_ptr_nxt;
  logic               w_take;
  logic               w_ev_end;
  logic               w_lk_end;
  logic               w_wd_hit;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .i_req   (src_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_take   = (r_state == IDLE) && !r_leak_pending
                    && (|src_valid);
  assign w_ev_end = (r_state == WAIT_EV)
                    && (event_done || w_wd_hit);
  assign w_lk_end = (r_state == LEAK)
                    && (leak_ack || w_wd_hit);
  assign w_ptr_nxt = (r_event_src == IW'(NUM_SRC - 1))
                     ? '0 : r_event_src + 1'b1;

  // Pop is combinational so it lands in the grant cycle; masked in reset.
  assign src_pop        = w_grant & {NUM_SRC{w_take && reset_n}};
  assign event_received = (r_state == ISSUE);
  assign leak_req       = (r_state == LEAK);
  assign busy           = (r_state != IDLE);
  assign event_addr     = r_event_addr;
  assign event_src      = r_event_src;
  assign leak_overrun   = r_leak_overrun;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_leak_pending)  w_state_nxt = LEAK;
        else if (|src_valid) w_state_nxt = ISSUE;
      end
      ISSUE:   w_state_nxt = WAIT_EV;
      WAIT_EV: if (w_ev_end) w_state_nxt = IDLE;
      LEAK:    if (w_lk_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_leak_pending <= 1'b0;
      r_leak_overrun <= 1'b0;
      r_event_addr   <= '0;
      r_event_src    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_event_addr <= src_addr[w_idx*ADDR_W +: ADDR_W];
        r_event_src  <= w_idx;
      end
      if (w_ev_end) r_rr_ptr <= w_ptr_nxt;
      // A tick coinciding with the leak completion re-arms the next pass.
      if (timestep_tick)  r_leak_pending <= 1'b1;
      else if (w_lk_end)  r_leak_pending <= 1'b0;
      if (timestep_tick && r_leak_pending && !w_lk_end)
        r_leak_overrun <= 1'b1;
    end
  end

`ifdef SNN_SCHED_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] r_wd_cnt;
  logic                 r_sched_err;
  logic                 w_wd_run;

  assign w_wd_run = (r_state == WAIT_EV) || (r_state == LEAK);
  // Abort on the edge where the counter would reach all-ones.
  assign w_wd_hit = w_wd_run
                    && (r_wd_cnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
  assign sched_err = r_sched_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt    <= '0;
      r_sched_err <= 1'b0;
    end else begin
      if (!w_wd_run) r_wd_cnt <= '0;
      else           r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_hit)  r_sched_err <= 1'b1;
    end
  end
`else
  assign w_wd_hit  = 1'b0;
  assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_event_sched.sv
// Scoreboard bench for snn_event_sched: directed vectors, queued expectations.
// Watchdog scenario follows SNN_SCHED_WATCHDOG_EN.
module tb_snn_event_sched;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [15:0] src_addr = '0;
  logic [3:0]  src_pop;
  logic        event_received;
  logic [3:0]  event_addr;
  logic [1:0]  event_src;
  logic        event_done = 1'b0;
  logic        timestep_tick = 1'b0;
  logic        leak_req;
  logic        leak_ack = 1'b0;
  logic        busy;
  logic        leak_overrun;
  logic        sched_err;

  always #5 clock = ~clock;

  snn_event_sched #(
    .NUM_SRC(4), .ADDR_W(4), .TIMEOUT_W(4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .src_valid      (src_valid),
    .src_addr       (src_addr),
    .src_pop        (src_pop),
    .event_received (event_received),
    .event_addr     (event_addr),
    .event_src      (event_src),
    .event_done     (event_done),
    .timestep_tick  (timestep_tick),
    .leak_req       (leak_req),
    .leak_ack       (leak_ack),
    .busy           (busy),
    .leak_overrun   (leak_overrun),
    .sched_err      (sched_err)
  );

  typedef struct {
    bit lk;
    int src;
    int addr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic [3:0] prev_pop = '0;
  logic       prev_lk = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_ev(int s, int a);
    exp_t e;
    e.lk = 1'b0; e.src = s; e.addr = a;
    q.push_back(e);
  endtask

  task automatic push_lk();
    exp_t e;
    e.lk = 1'b1; e.src = 0; e.addr = 0;
    q.push_back(e);
  endtask

  // Monitor: every issued event or leak start must match the queue head.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (event_received) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got src %0d expected none",
                   event_src);
        end else begin
          e = q.pop_front();
          chk("ev_kind", 32'(e.lk), 32'd0);
          chk("ev_src", 32'(event_src), e.src);
          chk("ev_addr", 32'(event_addr), e.addr);
          chk("pop_before_recv", 32'(prev_pop), 32'(1) << e.src);
        end
      end
      if (leak_req && !prev_lk) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_leak: got leak expected none");
        end else begin
          e = q.pop_front();
          chk("leak_kind", 32'(e.lk), 32'd1);
        end
      end
    end
    prev_pop = src_pop;
    prev_lk  = leak_req;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_done();
    event_done = 1'b1; tick(); event_done = 1'b0;
  endtask

  task automatic pulse_ack();
    leak_ack = 1'b1; tick(); leak_ack = 1'b0;
  endtask

  task automatic pulse_tick();
    timestep_tick = 1'b1; tick(); timestep_tick = 1'b0;
  endtask

  task automatic wait_for(bit lk, string nm);
    int n;
    n = 0;
    while (!(lk ? leak_req : event_received) && n < 60) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < 60), 32'd1);
  endtask

  task automatic do_reset(logic [3:0] v, logic [15:0] a);
    tick();
    reset_n = 1'b0;
    src_valid = v; src_addr = a;
    event_done = 1'b0; timestep_tick = 1'b0; leak_ack = 1'b0;
    tick(2);
    chk("reset_outputs",
        32'({src_pop, event_received, event_addr, event_src,
             leak_req, busy, leak_overrun, sched_err}), 32'd0);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    // 1: reset with requests held, first grant after release
    do_reset(4'b0101, 16'h0A05);
    push_ev(0, 5);
    chk("t1_first_pop", 32'(src_pop), 32'h1);
    tick();
    wait_for(0, "t1_recv");
    src_valid = '0;
    tick(2);
    pulse_done();
    tick(2);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: round robin over four always-valid sources
    do_reset(4'hF, {4'd12, 4'd9, 4'd7, 4'd3});
    push_ev(0, 3); push_ev(1, 7); push_ev(2, 9);
    push_ev(3, 12); push_ev(0, 3);
    for (int i = 0; i < 5; i++) begin
      wait_for(0, "t2_recv");
      if (i == 4) src_valid = '0;
      tick(5);
      pulse_done();
    end
    tick(2);
    chk("t2_queue_drained", 32'(q.size()), 32'd0);

    // 3: tick during an event pass; leak before next grant
    do_reset(4'b0011, 16'h0064);
    push_ev(0, 4);
    wait_for(0, "t3_recv0");
    tick();
    timestep_tick = 1'b1;
    push_lk(); push_ev(1, 6);
    tick();
    timestep_tick = 1'b0;
    tick();
    pulse_done();
    chk("t3_no_pop_leak_pending", 32'(src_pop), 32'd0);
    wait_for(1, "t3_leak");
    tick(3);
    chk("t3_leak_held", 32'(leak_req), 32'd1);
    chk("t3_no_pop_in_leak", 32'(src_pop), 32'd0);
    pulse_ack();
    wait_for(0, "t3_recv1");
    src_valid = '0;
    tick(2);
    pulse_done();
    tick(2);

    // 4: tick with ack re-arms; double tick sets overrun
    do_reset(4'b0000, 16'h0000);
    push_lk(); push_lk();
    pulse_tick();
    wait_for(1, "t4_leak_a");
    leak_ack = 1'b1; timestep_tick = 1'b1;
    tick();
    leak_ack = 1'b0; timestep_tick = 1'b0;
    chk("t4_no_overrun_on_ack", 32'(leak_overrun), 32'd0);
    tick();
    chk("t4_second_leak", 32'(leak_req), 32'd1);
    pulse_ack();
    tick();
    chk("t4_idle_after", 32'(busy), 32'd0);
    push_lk();
    pulse_tick();
    pulse_tick();
    chk("t4_overrun_set", 32'(leak_overrun), 32'd1);
    pulse_ack();
    tick(3);
    chk("t4_overrun_sticky", 32'(leak_overrun), 32'd1);
    chk("t4_single_leak", 32'(busy), 32'd0);

    // 5: spurious handshakes are ignored
    do_reset(4'b0000, 16'h0000);
    pulse_done();
    pulse_ack();
    chk("t5_idle_spurious",
        32'({busy, event_received, leak_req, src_pop}), 32'd0);
    src_valid = 4'b0100;
    src_addr  = 16'h0800;
    push_ev(2, 8);
    wait_for(0, "t5_recv");
    src_valid = '0;
    tick();
    pulse_ack();
    chk("t5_wait_held",
        32'({busy, event_received, leak_req}), 32'b100);
    tick(3);
    pulse_done();
    chk("t5_back_idle", 32'(busy), 32'd0);
    tick(2);
    chk("t5_no_regrant", 32'({busy, src_pop}), 32'd0);

`ifdef SNN_SCHED_WATCHDOG_EN
    // 6: watchdog aborts a stuck event pass
    do_reset(4'b0011, 16'h0021);
    push_ev(0, 1); push_ev(1, 2);
    wait_for(0, "t6_recv0");
    tick();
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("t6_wait_cycles", 32'(n), 32'd15);
    chk("t6_sched_err", 32'(sched_err), 32'd1);
    chk("t6_next_pop", 32'(src_pop), 32'b0010);
    wait_for(0, "t6_recv1");
    src_valid = '0;
    tick(2);
    pulse_done();
    tick(2);
`else
    // 6: without watchdog the pass waits indefinitely
    do_reset(4'b0001, 16'h0001);
    push_ev(0, 1);
    wait_for(0, "t6_recv");
    src_valid = '0;
    tick();
    n = 0;
    repeat (100) begin
      if (!busy || sched_err) n++;
      tick();
    end
    chk("t6_stays_wait", 32'(n), 32'd0);
    chk("t6_no_err", 32'(sched_err), 32'd0);
    pulse_done();
    tick(2);
    chk("t6_released", 32'(busy), 32'd0);
`endif

    tick(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/snn_event_sched.md
Name: snn_event_sched

Overview:
Front-end scheduler for the SNN core controller. It arbitrates round-robin among NUM_SRC sensor event sources and issues one event at a time to the controller. It waits for the controller to finish the event's weight-accumulate pass before issuing the next one. It also interleaves per-timestep leak passes, so the membrane potential memory is owned by exactly one operation at any time.

Parameters:
NUM_SRC, 4, number of sensor event sources (2..8)
ADDR_W, 4, sensor event address width
TIMEOUT_W, 8, watchdog counter width (used only with SNN_SCHED_WATCHDOG_EN)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  source i has an event at its FIFO head
src_addr  in  NUM_SRC*ADDR_W  head addresses; source i occupies bits [i*ADDR_W +: ADDR_W]
src_pop  out  NUM_SRC  one-hot, one-cycle pop strobe to the granted source FIFO
event_received  out  1  one-cycle strobe to the controller: start an event pass
event_addr  out  ADDR_W  latched event address; held stable from ISSUE until the next grant
event_src  out  $clog2(NUM_SRC)  index of the granted source
event_done  in  1  controller pulse: event pass finished
timestep_tick  in  1  one-cycle timestep boundary pulse
leak_req  out  1  level request for a leak pass to the controller
leak_ack  in  1  controller pulse: leak pass finished
busy  out  1  high in every state except IDLE
leak_overrun  out  1  sticky flag: a tick arrived while a leak was still pending
sched_err  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0, leak_pending=0.
  - All outputs 0, including event_addr and event_src.
  - Reset mid-pass abandons the pass; no pop or strobe is re-issued after release.
- FSM states: IDLE, ISSUE, WAIT_EV, LEAK.
- IDLE:
  - If leak_pending=1, go to LEAK. Leak has priority over events.
  - Else if any src_valid is set:
    - grant g = the first valid source searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
    - Latch event_addr=src_addr[g] and event_src=g.
    - Pulse src_pop[g] in the same cycle.
    - Go to ISSUE.
- ISSUE: event_received=1 for exactly one cycle; go to WAIT_EV.
- WAIT_EV:
  - On event_done: rr_ptr=(g+1) mod NUM_SRC; go to IDLE.
- LEAK:
  - leak_req=1 held until leak_ack.
  - On leak_ack: clear leak_pending, go to IDLE.
- Latency: a valid source seen in IDLE gets its pop in that cycle and event_received the next cycle. Minimum back-to-back spacing is 3 cycles plus controller time.
- Leak tracking:
  - timestep_tick sets leak_pending.
  - A tick while leak_pending=1 sets leak_overrun (sticky until reset).
  - A tick in the same cycle as a leak_ack leaves leak_pending=1, so the new tick wins; this does not set the overrun flag.
- event_done outside WAIT_EV and leak_ack outside LEAK are ignored.
- src_valid dropping after grant has no effect; the grant is already committed.
- A source is never popped while its src_valid=0.

Optional Feature:
Macro SNN_SCHED_WATCHDOG_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT_EV or LEAK and increments each cycle in those states.
  - At all-ones, the FSM aborts to IDLE and sets sched_err (sticky).
  - On an aborted event, rr_ptr still advances.
  - On an aborted leak, leak_pending clears.
- Undefined: no counter; the FSM waits forever; sched_err is constant 0.

Decomposition:
- Package snn_pkg holds:
  - the sched_state_t enum (IDLE, ISSUE, WAIT_EV, LEAK);
  - EVT_ADDR_W=4;
  - NUM_NEURONS=16.
- One sub-module, rr_arbiter:
  - parameterised NUM_SRC;
  - inputs req and ptr; outputs one-hot grant and binary index;
  - purely combinational.

Test Plan:
1. Reset with src_valid=4'b0101 held -> all outputs 0. After release: pop[0] in the first cycle, event_received the next cycle with event_addr=src_addr[0], event_src=0.
2. All four sources valid continuously, addrs 3,7,9,12, event_done returned 5 cycles after each event_received -> grant order 0,1,2,3,0; each pop precedes its event_received by exactly 1 cycle.
3. timestep_tick during WAIT_EV with src 1 also valid -> after event_done, LEAK is entered before src 1 is granted. leak_req stays high until leak_ack, then src 1 is granted.
4. Two ticks with no leak_ack in between -> leak_overrun=1 and stays set. A tick coincident with leak_ack -> a second leak pass follows immediately.
5. Spurious event_done in IDLE and spurious leak_ack in WAIT_EV -> no state change and no strobes.
6. With SNN_SCHED_WATCHDOG_EN and TIMEOUT_W=4, withhold event_done -> return to IDLE after 15 cycles in WAIT_EV, sched_err=1, and the next grant goes to the following source. Without the macro, the bench stays in WAIT_EV for 100 cycles with sched_err=0.
